// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through a start-pulse/busy handshake.
// Optional UART_TX_FIFO_STATS_EN adds sent_cnt and clr_stats; the default build omits both.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int GUARD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic             overflow,
    output logic             tx_start,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_busy,
`ifdef UART_TX_FIFO_STATS_EN
    input  logic             clr_stats,
    output logic [15:0]      sent_cnt,
`endif
    output logic             hs_err
);

    localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [GW-1:0]    guard_cnt;
    logic             push;
    logic             pop;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    // Both qualifiers use start-of-cycle state, so a write at full is dropped even if a pop frees a slot.
    assign push = wr_en & ~full;
    assign pop  = (state == IDLE) & ~empty & ~tx_busy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            hs_err    <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            guard_cnt <= '0;
            state     <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end

            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_start  <= 1'b1;
                        tx_data   <= mem[rd_ptr];
                        guard_cnt <= '0;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    // On timeout the byte is treated as sent; the transmitter never acknowledged it.
                    if (tx_busy) begin
                        state <= WAIT;
                    end else if (guard_cnt == GW'(GUARD - 1)) begin
                        hs_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                WAIT: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef UART_TX_FIFO_STATS_EN
            if (clr_stats) begin
                overflow <= 1'b0;
                hs_err   <= 1'b0;
            end
`endif
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            sent_cnt <= '0;
        end else if (pop) begin
            sent_cnt <= sent_cnt + 16'd1;
        end
    end
`endif

endmodule
